ps2_key_decoder: RTL

//  Parametrised successor to the calculator keyboard decoder. Consumes raw scan-code bytes from
//  PS2_Controller (received_data/received_data_en), tracks shift plus E0-extended and F0-break prefixes,
//  and translates key presses into ASCII-style codes. Codes are buffered in a FIFO and drained by the

---
 rtl/ps2_key_decoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 set-2 scan bytes into calculator key codes.
// Tracks E0/F0 prefixes and shift state, optionally filters typematic
// repeats, and queues codes in a show-ahead FIFO drained by valid/ready.
module ps2_key_decoder #(
    parameter int         FIFO_DEPTH  = 8,
    parameter bit         REPEAT_EN   = 1'b1,
    parameter logic [7:0] RETURN_CODE = 8'h80,
    parameter logic [7:0] DELETE_CODE = 8'h08,
    localparam int        PTR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [7:0]       scan_byte,
    input  logic             scan_byte_en,
    output logic [7:0]       char_data,
    output logic             char_valid,
    input  logic             char_ready,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             shift_held,
    output logic [7:0]       last_char
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    localparam logic [7:0]     PFX_EXT  = 8'hE0;
    localparam logic [7:0]     PFX_BRK  = 8'hF0;
    localparam logic [7:0]     SC_LSHFT = 8'h12;
    localparam logic [7:0]     SC_RSHFT = 8'h59;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    state_t           state, state_next;
    logic             is_make, is_break, ext;
    logic [8:0]       key;          // {ext, scan code} of the current byte
    logic [8:0]       held_key;     // last pushed make, for repeat filtering
    logic             shift_l, shift_r;
    logic             hit;
    logic [7:0]       code;
    logic             push_req, pop, full, do_write;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];

    // Translate one make code into a key code; hit=0 for keys we ignore.
    function automatic logic [8:0] decode_key(input logic e, input logic [7:0] sc,
                                              input logic sh);
        logic [8:0] r;
        r = 9'd0;
        if (!e) begin
            case (sc)
                8'h45: r = {1'b1, sh ? 8'd41 : 8'd48};
                8'h46: r = {1'b1, sh ? 8'd40 : 8'd57};
                8'h3E: r = {1'b1, sh ? 8'd42 : 8'd56};
                8'h16: r = {1'b1, 8'd49};
                8'h1E: r = {1'b1, 8'd50};
                8'h26: r = {1'b1, 8'd51};
                8'h25: r = {1'b1, 8'd52};
                8'h2E: r = {1'b1, 8'd53};
                8'h36: r = {1'b1, 8'd54};
                8'h3D: r = {1'b1, 8'd55};
                8'h55: r = {1'b1, sh ? 8'd43 : 8'd61};
                8'h4E: r = {1'b1, 8'd45};
                8'h4A: r = {1'b1, 8'd47};
                8'h29: r = {1'b1, 8'd32};
                8'h79: r = {1'b1, 8'd43};
                8'h7B: r = {1'b1, 8'd45};
                8'h7C: r = {1'b1, 8'd42};
                8'h5A: r = {1'b1, RETURN_CODE};
                8'h66: r = {1'b1, DELETE_CODE};
                default: r = 9'd0;
            endcase
        end else begin
            case (sc)
                8'h4A: r = {1'b1, 8'd47};
                8'h5A: r = {1'b1, RETURN_CODE};
                default: r = 9'd0;
            endcase
        end
        return r;
    endfunction

    // Prefix FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Prefix FSM next state and classification of the current byte.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        is_make    = 1'b0;
        is_break   = 1'b0;
        ext        = 1'b0;
        if (scan_byte_en) begin
            case (state)
                ST_IDLE: begin
                    if (scan_byte == PFX_EXT)      state_next = ST_EXT;
                    else if (scan_byte == PFX_BRK) state_next = ST_BRK;
                    else                           is_make    = 1'b1;
                end
                ST_EXT: begin
                    if (scan_byte == PFX_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        is_make    = 1'b1;
                        ext        = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    is_break   = 1'b1;
                    state_next = ST_IDLE;
                end
                default: begin
                    is_break   = 1'b1;
                    ext        = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign key        = {ext, scan_byte};
    assign shift_held = shift_l | shift_r;
    assign {hit, code} = decode_key(ext, scan_byte, shift_held);

    assign push_req   = is_make && hit && (REPEAT_EN || (key != held_key));
    assign pop        = char_valid && char_ready;
    assign full       = (fifo_count == FULL_CNT);
    assign do_write   = push_req && (!full || pop);
    assign char_valid = (fifo_count != '0);
    assign char_data  = char_valid ? mem[rd_ptr] : 8'd0;

    // Shift flags, repeat-filter register and last pushed code.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            held_key  <= 9'd0;
            last_char <= 8'd0;
        end else begin
            if (is_make  && key == {1'b0, SC_LSHFT}) shift_l <= 1'b1;
            if (is_break && key == {1'b0, SC_LSHFT}) shift_l <= 1'b0;
            if (is_make  && key == {1'b0, SC_RSHFT}) shift_r <= 1'b1;
            if (is_break && key == {1'b0, SC_RSHFT}) shift_r <= 1'b0;
            if (push_req) begin
                held_key  <= key;
                last_char <= code;
            end else if (is_break && key == held_key) begin
                held_key  <= 9'd0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_write && !pop)      fifo_count <= fifo_count + (PTR_W+1)'(1);
            else if (!do_write && pop) fifo_count <= fifo_count - (PTR_W+1)'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clr_overflow)        overflow <= 1'b0;
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array is not reset; occupancy gates char_data, so stale contents are never seen.
    always_ff @(posedge CLOCK_50) begin
        if (do_write) mem[wr_ptr] <= code;
    end

endmodule
